// File: rtl/exe_mem_buffer_pkg.sv
// Shared constants for the execute/memory pipeline buffer.
//   - Register-file / status-register widths
//   - Flag bit positions inside the status vector {Z, C, N, V}
//   - Buffer FSM state encodings
package exe_mem_buffer_pkg;

  localparam int REGISTER_FILE_LEN = 32;
  localparam int STATUS_REG_LEN    = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    EXMB_EMPTY = 2'd0,
    EXMB_ONE   = 2'd1,
    EXMB_FULL  = 2'd2
  } exmb_state_e;

endpackage

// File: rtl/exe_mem_entry_reg.sv
// One buffered instruction slot of the execute/memory buffer.
// Load-enabled register holding every per-instruction field; cleared
// synchronously by rst.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load              capture d_* on this edge
//   d_*               incoming field values
//   q_*               stored field values
module exe_mem_entry_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d_res,
  input  logic [DATA_W-1:0] d_st_val,
  input  logic [DEST_W-1:0] d_dest,
  input  logic              d_wb_en,
  input  logic              d_mem_r,
  input  logic              d_mem_w,
  output logic [DATA_W-1:0] q_res,
  output logic [DATA_W-1:0] q_st_val,
  output logic [DEST_W-1:0] q_dest,
  output logic              q_wb_en,
  output logic              q_mem_r,
  output logic              q_mem_w
);

  logic [DATA_W-1:0] res_q,    res_d;
  logic [DATA_W-1:0] st_val_q, st_val_d;
  logic [DEST_W-1:0] dest_q,   dest_d;
  logic              wb_en_q,  wb_en_d;
  logic              mem_r_q,  mem_r_d;
  logic              mem_w_q,  mem_w_d;

  always_comb begin
    res_d    = res_q;
    st_val_d = st_val_q;
    dest_d   = dest_q;
    wb_en_d  = wb_en_q;
    mem_r_d  = mem_r_q;
    mem_w_d  = mem_w_q;
    if (load) begin
      res_d    = d_res;
      st_val_d = d_st_val;
      dest_d   = d_dest;
      wb_en_d  = d_wb_en;
      mem_r_d  = d_mem_r;
      mem_w_d  = d_mem_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q    <= '0;
      st_val_q <= '0;
      dest_q   <= '0;
      wb_en_q  <= 1'b0;
      mem_r_q  <= 1'b0;
      mem_w_q  <= 1'b0;
    end else begin
      res_q    <= res_d;
      st_val_q <= st_val_d;
      dest_q   <= dest_d;
      wb_en_q  <= wb_en_d;
      mem_r_q  <= mem_r_d;
      mem_w_q  <= mem_w_d;
    end
  end

  assign q_res    = res_q;
  assign q_st_val = st_val_q;
  assign q_dest   = dest_q;
  assign q_wb_en  = wb_en_q;
  assign q_mem_r  = mem_r_q;
  assign q_mem_w  = mem_w_q;

endmodule

// File: rtl/exe_mem_buffer.sv
// Execute -> memory two-entry skid buffer that also owns the status register.
// The memory stage may stall without in_ready depending combinationally on
// out_ready. Flags commit when an instruction with the S bit is accepted.
//
// Optional feature: define EXE_MEM_FWD_EN to add head-entry forwarding
// outputs (fwd_valid, fwd_dest, fwd_res) for the hazard unit.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               branch-taken flush, empties the buffer
//   in_valid/in_ready   execute-side handshake
//   in_*                executed instruction fields, flags and S bit
//   out_valid/out_ready memory-side handshake
//   out_*               head entry fields
//   status_reg          committed flags {Z, C, N, V}; bit 2 is carry
//
// state | meaning
// ------+------------------------------------------
// EMPTY | no entry held, out_valid low
// ONE   | head holds one entry
// FULL  | head and tail both hold entries, in_ready low
module exe_mem_buffer
  import exe_mem_buffer_pkg::*;
#(
  parameter int DATA_W = REGISTER_FILE_LEN,
  parameter int DEST_W = 4,
  parameter int STAT_W = STATUS_REG_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_res,
  input  logic [STAT_W-1:0] in_status,
  input  logic              in_s,
  input  logic [DATA_W-1:0] in_st_val,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_wb_en,
  input  logic              in_mem_r,
  input  logic              in_mem_w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [DATA_W-1:0] out_st_val,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_wb_en,
  output logic              out_mem_r,
  output logic              out_mem_w,
`ifdef EXE_MEM_FWD_EN
  output logic              fwd_valid,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_res,
`endif
  output logic [STAT_W-1:0] status_reg
);

  exmb_state_e       state_q, state_d;
  logic [STAT_W-1:0] status_q, status_d;

  logic push;
  logic pop;
  logic head_load;
  logic head_from_tail;
  logic tail_load;

  logic [DATA_W-1:0] tail_res;
  logic [DATA_W-1:0] tail_st_val;
  logic [DEST_W-1:0] tail_dest;
  logic              tail_wb_en;
  logic              tail_mem_r;
  logic              tail_mem_w;

  logic [DATA_W-1:0] head_d_res;
  logic [DATA_W-1:0] head_d_st_val;
  logic [DEST_W-1:0] head_d_dest;
  logic              head_d_wb_en;
  logic              head_d_mem_r;
  logic              head_d_mem_w;

  // flush blocks acceptance, so a flushed instruction never touches the flags
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EXMB_EMPTY;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EXMB_EMPTY;
    end else begin
      case (state_q)
        EXMB_EMPTY: if (push) state_d = EXMB_ONE;
        EXMB_ONE: begin
          if (push && !pop)      state_d = EXMB_FULL;
          else if (!push && pop) state_d = EXMB_EMPTY;
        end
        EXMB_FULL: if (pop) state_d = EXMB_ONE;
        default: state_d = EXMB_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready       = (state_q != EXMB_FULL);
    out_valid      = (state_q != EXMB_EMPTY);
    head_load      = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;
    status_d       = (push && in_s) ? in_status : status_q;
    case (state_q)
      EXMB_EMPTY: head_load = push;
      EXMB_ONE: begin
        head_load = push & pop;
        tail_load = push & ~pop;
      end
      EXMB_FULL: begin
        head_load      = pop;
        head_from_tail = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    head_d_res    = in_res;
    head_d_st_val = in_st_val;
    head_d_dest   = in_dest;
    head_d_wb_en  = in_wb_en;
    head_d_mem_r  = in_mem_r;
    head_d_mem_w  = in_mem_w;
    if (head_from_tail) begin
      head_d_res    = tail_res;
      head_d_st_val = tail_st_val;
      head_d_dest   = tail_dest;
      head_d_wb_en  = tail_wb_en;
      head_d_mem_r  = tail_mem_r;
      head_d_mem_w  = tail_mem_w;
    end
  end

  exe_mem_entry_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W)) u_head (
    .clk      (clk),
    .rst      (rst),
    .load     (head_load),
    .d_res    (head_d_res),
    .d_st_val (head_d_st_val),
    .d_dest   (head_d_dest),
    .d_wb_en  (head_d_wb_en),
    .d_mem_r  (head_d_mem_r),
    .d_mem_w  (head_d_mem_w),
    .q_res    (out_res),
    .q_st_val (out_st_val),
    .q_dest   (out_dest),
    .q_wb_en  (out_wb_en),
    .q_mem_r  (out_mem_r),
    .q_mem_w  (out_mem_w)
  );

  exe_mem_entry_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W)) u_tail (
    .clk      (clk),
    .rst      (rst),
    .load     (tail_load),
    .d_res    (in_res),
    .d_st_val (in_st_val),
    .d_dest   (in_dest),
    .d_wb_en  (in_wb_en),
    .d_mem_r  (in_mem_r),
    .d_mem_w  (in_mem_w),
    .q_res    (tail_res),
    .q_st_val (tail_st_val),
    .q_dest   (tail_dest),
    .q_wb_en  (tail_wb_en),
    .q_mem_r  (tail_mem_r),
    .q_mem_w  (tail_mem_w)
  );

  assign status_reg = status_q;

`ifdef EXE_MEM_FWD_EN
  // Loads are excluded: their result is an address, not the write-back value.
  assign fwd_valid = out_valid & out_wb_en & ~out_mem_r;
  assign fwd_dest  = out_dest;
  assign fwd_res   = out_res;
`endif

endmodule
